// File: rtl/cv32e40x_pkg.sv
// +----------------------------------------------------------------------+
// | cv32e40x_pkg                                                         |
// | Shared types for the cv32e40x core slice (fence.i flush sequencing). |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package cv32e40x_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    WAIT_LSU = 2'b01,
    REQ      = 2'b10,
    DONE     = 2'b11
  } fencei_state_e;

endpackage

`default_nettype wire

// File: rtl/cv32e40x_fencei_flush_ctrl_sva.sv
// +----------------------------------------------------------------------+
// | cv32e40x_fencei_flush_ctrl_sva                                       |
// | Handshake and pulse properties, bound into the flush controller.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module cv32e40x_fencei_flush_ctrl_sva (
  input logic clk,
  input logic rst,
  input logic start_accept,
  input logic busy_o,
  input logic done_o,
  input logic fencei_flush_req_o,
  input logic fencei_flush_ack_i
);

  a_req_stable : assert property (@(posedge clk)
    (fencei_flush_req_o && !fencei_flush_ack_i && !rst) |=> fencei_flush_req_o);

  a_done_pulse : assert property (@(posedge clk)
    (done_o && !rst) |=> !done_o);

  a_no_start_busy : assert property (@(posedge clk)
    busy_o |-> !start_accept);

endmodule

bind cv32e40x_fencei_flush_ctrl cv32e40x_fencei_flush_ctrl_sva u_sva (
  .clk                (clk),
  .rst                (rst),
  .start_accept       (w_start_accept),
  .busy_o             (busy_o),
  .done_o             (done_o),
  .fencei_flush_req_o (fencei_flush_req_o),
  .fencei_flush_ack_i (fencei_flush_ack_i)
);

`default_nettype wire

// File: rtl/cv32e40x_sat_counter.sv
// +----------------------------------------------------------------------+
// | cv32e40x_sat_counter                                                 |
// | Up-counter with synchronous clear that sticks at its maximum value.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module cv32e40x_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] c_max = '1;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && (cnt != c_max)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cv32e40x_fencei_flush_ctrl.sv
// +----------------------------------------------------------------------+
// | cv32e40x_fencei_flush_ctrl                                           |
// | Drains the LSU, then runs the fence.i flush req/ack handshake.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module cv32e40x_fencei_flush_ctrl
  import cv32e40x_pkg::*;
#(
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned ACK_TIMEOUT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 kill_i,
  input  logic                 lsu_busy_i,
  output logic                 fencei_flush_req_o,
  input  logic                 fencei_flush_ack_i,
  output logic                 busy_o,
  output logic                 halt_if_o,
  output logic                 done_o,
  output logic [CNT_WIDTH-1:0] cycles_o,
  output logic                 timeout_o
);

  fencei_state_e r_state;
  logic          w_start_accept;
  logic          w_active;

  assign w_start_accept = start_i && (r_state == IDLE);
  assign w_active       = (r_state == WAIT_LSU) || (r_state == REQ);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) r_state <= lsu_busy_i ? WAIT_LSU : REQ;
        end
        WAIT_LSU: begin
          // An abort beats a draining LSU arriving in the same cycle
          if (kill_i)           r_state <= IDLE;
          else if (!lsu_busy_i) r_state <= REQ;
        end
        REQ: begin
          if (fencei_flush_ack_i) r_state <= DONE;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign fencei_flush_req_o = (r_state == REQ);
  assign busy_o             = (r_state != IDLE);
  assign halt_if_o          = busy_o;
  assign done_o             = (r_state == DONE);

  cv32e40x_sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_latency_cnt (
    .clk (clk),
    .rst (rst),
    .clr (w_start_accept),
    .en  (w_active),
    .cnt (cycles_o)
  );

  generate
    if (ACK_TIMEOUT != 0) begin : g_timeout
      localparam logic [CNT_WIDTH-1:0] c_req_limit = CNT_WIDTH'(ACK_TIMEOUT - 1);

      logic [CNT_WIDTH-1:0] w_req_cnt;
      logic                 r_timeout;

      cv32e40x_sat_counter #(
        .WIDTH (CNT_WIDTH)
      ) u_req_cnt (
        .clk (clk),
        .rst (rst),
        .clr (w_start_accept),
        .en  (r_state == REQ),
        .cnt (w_req_cnt)
      );

      // Sets once the ACK_TIMEOUT-th REQ cycle passes without an ack
      always_ff @(posedge clk) begin
        if (rst || w_start_accept) begin
          r_timeout <= 1'b0;
        end else if ((r_state == REQ) && !fencei_flush_ack_i && (w_req_cnt >= c_req_limit)) begin
          r_timeout <= 1'b1;
        end
      end

      assign timeout_o = r_timeout;
    end else begin : g_no_timeout
      assign timeout_o = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire
